// File: rtl/serial_word_collector.sv
// Collects LSB-first serial bits into a WIDTH-bit word and offers it on a valid/ready output.
// Latency: out_valid rises on the edge that captures the WIDTH-th valid bit.
// Backpressure: the word is held until out_ready; bits arriving meanwhile are dropped and flagged in overrun.
module serial_word_collector #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   shreg, shreg_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic [WIDTH-1:0]   data_nxt;
  logic               overrun_nxt;
  logic [WIDTH-1:0]   shifted;
  logic               last_bit;

  // New bits enter at the MSB and move right, so the first bit ends up in bit 0.
  generate
    if (WIDTH == 1) begin : g_one
      assign shifted = bit_in;
    end else begin : g_many
      assign shifted = {bit_in, shreg[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit  = (count == CNT_W'(WIDTH - 1));
  assign busy      = (state == SHIFT);
  assign out_valid = (state == HOLD);

  // State register and datapath registers; reset discards any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      count    <= '0;
      data_out <= '0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      count    <= count_nxt;
      data_out <= data_nxt;
      overrun  <= overrun_nxt;
    end
  end

  // Next-state and datapath update; start takes priority over a bit in the same cycle.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    count_nxt   = count;
    data_nxt    = data_out;
    overrun_nxt = overrun;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = SHIFT;
          shreg_nxt   = '0;
          count_nxt   = '0;
          overrun_nxt = 1'b0;
        end
      end
      SHIFT: begin
        if (start) begin
          shreg_nxt   = '0;
          count_nxt   = '0;
          overrun_nxt = 1'b0;
        end else if (bit_valid) begin
          shreg_nxt = shifted;
          if (last_bit) begin
            data_nxt  = shifted;
            count_nxt = '0;
            state_nxt = HOLD;
          end else begin
            count_nxt = count + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (start) begin
            state_nxt   = SHIFT;
            shreg_nxt   = '0;
            count_nxt   = '0;
            overrun_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (bit_valid) begin
          overrun_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_word_collector.sv
module tb_serial_word_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] data_out;
  logic       out_valid, busy, overrun;

  // single-bit instance for the WIDTH=1 corner
  logic       start1 = 1'b0, bit1 = 1'b0, bv1 = 1'b0, rdy1 = 1'b0;
  logic [0:0] data1;
  logic       valid1, busy1, ovr1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       start;
    logic       bit_in;
    logic       bit_valid;
    logic       out_ready;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       ovr;
  } vec_t;

  vec_t vecs[$];

  serial_word_collector #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .out_ready(out_ready), .data_out(data_out), .out_valid(out_valid),
    .busy(busy), .overrun(overrun)
  );

  serial_word_collector #(.WIDTH(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .bit_in(bit1), .bit_valid(bv1),
    .out_ready(rdy1), .data_out(data1), .out_valid(valid1),
    .busy(busy1), .overrun(ovr1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [7:0] d, input logic v,
                           input logic b, input logic o);
    check({name, ".data"}, {24'd0, data_out}, {24'd0, d});
    check({name, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    check({name, ".busy"}, {31'd0, busy}, {31'd0, b});
    check({name, ".ovr"}, {31'd0, overrun}, {31'd0, o});
  endtask

  task automatic add(input logic s, input logic b, input logic bv, input logic r,
                     input logic [7:0] d, input logic v, input logic bz, input logic o);
    vec_t e;
    e.start = s; e.bit_in = b; e.bit_valid = bv; e.out_ready = r;
    e.data = d; e.valid = v; e.busy = bz; e.ovr = o;
    vecs.push_back(e);
  endtask

  // Eight consecutive LSB-first bits of w; data_out holds prev until the last bit lands.
  task automatic add_word(input logic [7:0] w, input logic [7:0] prev);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) add(1'b0, w[i], 1'b1, 1'b0, w, 1'b1, 1'b0, 1'b0);
      else        add(1'b0, w[i], 1'b1, 1'b0, prev, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic drive(input logic s, input logic b, input logic bv, input logic r);
    @(negedge clk);
    start = s; bit_in = b; bit_valid = bv; out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] w;

    // Vector table: sequences 1, 3, 4, 5 plus idle/hold corner rows
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);          // start
    add_word(8'hA5, 8'h00);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);          // accept -> IDLE
    add(1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);          // IDLE ignores bits
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0);          // start
    add_word(8'hFF, 8'hA5);
    add(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);          // overrun sets
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);          // start ignored w/o ready
    add(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);          // accepted start clears
    add_word(8'h12, 8'hFF);
    add(1'b1, 1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 1'b0);          // back-to-back
    add_word(8'h81, 8'h12);
    add(1'b1, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1, 1'b0);          // back-to-back
    for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0);          // restart, bit dropped
    add_word(8'h5A, 8'h81);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);          // accept -> IDLE

    // Reset state, checked while reset is still asserted
    #3;
    check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      drive(vecs[k].start, vecs[k].bit_in, vecs[k].bit_valid, vecs[k].out_ready);
      check_all($sformatf("vec%0d", k), vecs[k].data, vecs[k].valid, vecs[k].busy, vecs[k].ovr);
    end

    // Sequence 2: 8'h3C with two idle cycles between bits
    w = 8'h3C;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("gap.start_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, w[i], 1'b1, 1'b0);
      check($sformatf("gap.bit%0d_valid", i), {31'd0, out_valid}, (i == 7) ? 32'd1 : 32'd0);
      if (i < 7) begin
        for (int g = 0; g < 2; g++) begin
          drive(1'b0, 1'b1, 1'b0, 1'b0);
          check($sformatf("gap.idle%0d_%0d", i, g), {31'd0, out_valid}, 32'd0);
        end
      end
    end
    check_all("gap.done", 8'h3C, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check_all("gap.accept", 8'h3C, 1'b0, 1'b0, 1'b0);

    // Sequence 6: asynchronous reset mid-word, between clock edges
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
    check("rstmid.busy_before", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_all("rstmid.async", 8'h00, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
    check_all("rstmid.ignored", 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    add_word(8'h96, 8'h00);
    w = 8'h96;
    for (int i = 0; i < 8; i++) drive(1'b0, w[i], 1'b1, 1'b0);
    check_all("rstmid.after", 8'h96, 1'b1, 1'b0, 1'b0);

    // WIDTH=1: each valid bit completes a word
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1;
    check("w1.busy", {31'd0, busy1}, 32'd1);
    @(negedge clk); start1 = 1'b0; bit1 = 1'b1; bv1 = 1'b1;
    @(posedge clk); #1;
    check("w1.valid", {31'd0, valid1}, 32'd1);
    check("w1.data", {31'd0, data1}, 32'd1);
    @(negedge clk); bv1 = 1'b0; start1 = 1'b1; rdy1 = 1'b1;
    @(posedge clk); #1;
    check("w1.b2b_busy", {31'd0, busy1}, 32'd1);
    @(negedge clk); start1 = 1'b0; rdy1 = 1'b0; bit1 = 1'b0; bv1 = 1'b1;
    @(posedge clk); #1;
    check("w1.data0", {31'd0, data1}, 32'd0);
    check("w1.valid2", {31'd0, valid1}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
